// File: rtl/speed_ctrl_v2.sv
// Train speed/direction controller: latches multiplexed joystick samples and
// updates speed/direction once per tick. Optional SPEED_LIMIT_EN adds i_limit.
module speed_ctrl_v2 #(
    parameter int         SPD_W      = 13,
    parameter int         DATA_W     = 16,
    parameter int         TICK_DIV   = 10000,
    parameter logic [7:0] CENTER     = 8'h31,
    parameter int         HOLD       = 2,
    parameter int         STEP_SHIFT = 2,
    parameter int         MAX_ACC    = 4,
    parameter int         MAX_BRK    = 8,
    parameter logic [7:0] DIR_LO     = 8'h32,
    parameter logic [7:0] DIR_HI     = 8'h36
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_channel,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_estop,
`ifdef SPEED_LIMIT_EN
    input  logic [SPD_W-1:0]  i_limit,
`endif
    output logic [SPD_W-1:0]  o_speed,
    output logic [1:0]        o_forward,
    output logic              o_tick,
    output logic              o_moving
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [SPD_W:0] SPD_MAX = {1'b0, {SPD_W{1'b1}}};
    localparam logic [SPD_W:0] BRK_E   = (SPD_W+1)'(MAX_BRK);
    localparam logic [8:0]     LO9     = 9'(int'(CENTER) - HOLD);
    localparam logic [8:0]     HI9     = 9'(int'(CENTER) + HOLD);

    typedef enum logic [1:0] {REV = 2'd0, STOP_R = 2'd1, STOP_F = 2'd2, FWD = 2'd3} dir_e;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [7:0]       smp, dir_s, thr_s;
    logic             dir_vld, thr_vld;
    dir_e             state, state_nxt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));
    assign smp  = i_data[DATA_W-1 -: 8];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            o_tick  <= 1'b0;
            dir_s   <= '0;
            thr_s   <= '0;
            dir_vld <= 1'b0;
            thr_vld <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + CNT_W'(1);
            o_tick <= tick;
            // A sample arriving on the tick cycle lands after this tick has read the latch.
            if (i_valid) begin
                if (i_channel) begin
                    thr_s   <= smp;
                    thr_vld <= 1'b1;
                end else begin
                    dir_s   <= smp;
                    dir_vld <= 1'b1;
                end
            end
        end
    end

    // Throttle step sizes; one spare bit keeps add/sub free of wrap-around.
    logic [8:0]     thr9, acc_d, brk_d, acc_raw, brk_raw, acc_st, brk_st;
    logic [SPD_W:0] spd_ext, acc_amt, brk_amt, sum, ceil, estop_spd, nxt_spd;
    logic           drive_ok;

    always_comb begin
        thr9     = {1'b0, thr_s};
        acc_d    = LO9 - thr9 - 9'd1;
        brk_d    = thr9 - HI9 - 9'd1;
        acc_raw  = (acc_d >> STEP_SHIFT) + 9'd1;
        brk_raw  = (brk_d >> STEP_SHIFT) + 9'd1;
        acc_st   = (acc_raw > 9'(MAX_ACC)) ? 9'(MAX_ACC) : acc_raw;
        brk_st   = (brk_raw > 9'(MAX_BRK)) ? 9'(MAX_BRK) : brk_raw;
        acc_amt  = (SPD_W+1)'(acc_st);
        brk_amt  = (SPD_W+1)'(brk_st);
        spd_ext  = {1'b0, o_speed};
        drive_ok = (state == FWD) || (state == REV);
        estop_spd = (spd_ext > BRK_E) ? spd_ext - BRK_E : '0;
`ifdef SPEED_LIMIT_EN
        ceil = {1'b0, i_limit};
`else
        ceil = SPD_MAX;
`endif
        sum     = spd_ext + acc_amt;
        nxt_spd = spd_ext;
        if (i_estop) begin
            nxt_spd = estop_spd;
`ifdef SPEED_LIMIT_EN
        end else if (o_speed > i_limit) begin
            nxt_spd = (spd_ext >= {1'b0, i_limit} + BRK_E) ? spd_ext - BRK_E : {1'b0, i_limit};
`endif
        end else if (drive_ok && thr_vld) begin
            if (thr9 < LO9)
                nxt_spd = (sum > ceil) ? ceil : sum;
            else if (thr9 > HI9)
                nxt_spd = (spd_ext > brk_amt) ? spd_ext - brk_amt : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  o_speed <= '0;
        else if (tick) o_speed <= nxt_spd[SPD_W-1:0];
    end

    // Direction FSM: only re-evaluated when standing still at the start of a tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= STOP_F;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tick && (o_speed == '0) && dir_vld && !i_estop) begin
            if (dir_s > DIR_HI)      state_nxt = FWD;
            else if (dir_s < DIR_LO) state_nxt = REV;
            else begin
                case (state)
                    FWD:     state_nxt = STOP_F;
                    REV:     state_nxt = STOP_R;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_comb begin
        o_forward = state;
        o_moving  = |o_speed;
    end
endmodule
